// File: rtl/jk_excite_seq.sv
// Excitation sequencer for a bank of downstream JK flip-flops: loads or toggles the
// bank, checks the fed-back Q against the expected word and re-drives on mismatch.
`timescale 1ns/1ps

module jk_excite_seq #(
   parameter int WIDTH     = 4,
   parameter int MAX_RETRY = 2
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic             IN_MODE,
   input  logic [WIDTH-1:0] IN_DATA,
   input  logic [WIDTH-1:0] Q_FB,
   output logic [WIDTH-1:0] J,
   output logic [WIDTH-1:0] K,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR
);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      CHECK
   } state_t;

   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   state_t           state;
   logic             modeReg;
   logic [WIDTH-1:0] dataReg;
   logic [WIDTH-1:0] expReg;
   logic [RW-1:0]    retryCnt;

   // Load-mode excitation: set bits that must rise, reset bits that must fall, hold the rest.
   function automatic logic [WIDTH-1:0] loadJ(input logic [WIDTH-1:0] tgt, input logic [WIDTH-1:0] q);
      return tgt & ~q;
   endfunction

   function automatic logic [WIDTH-1:0] loadK(input logic [WIDTH-1:0] tgt, input logic [WIDTH-1:0] q);
      return ~tgt & q;
   endfunction

   // J/K are zero in every cycle except DRIVE, so the bank only moves once per drive.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state    <= IDLE;
         modeReg  <= 1'b0;
         dataReg  <= '0;
         expReg   <= '0;
         retryCnt <= '0;
         J        <= '0;
         K        <= '0;
         DONE     <= 1'b0;
         ERR      <= 1'b0;
      end else begin
         J    <= '0;
         K    <= '0;
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (IN_VALID) begin
                  state    <= DRIVE;
                  modeReg  <= IN_MODE;
                  dataReg  <= IN_DATA;
                  expReg   <= IN_MODE ? (Q_FB ^ IN_DATA) : IN_DATA;
                  retryCnt <= '0;
                  ERR      <= 1'b0;
                  if (IN_MODE) begin
                     J <= IN_DATA;
                     K <= IN_DATA;
                  end else begin
                     J <= loadJ(IN_DATA, Q_FB);
                     K <= loadK(IN_DATA, Q_FB);
                  end
               end
            end
            DRIVE: begin
               state <= CHECK;
            end
            CHECK: begin
               if (Q_FB == expReg) begin
                  state <= IDLE;
                  DONE  <= 1'b1;
               end else if (!modeReg && (retryCnt < RW'(MAX_RETRY))) begin
                  // A toggle cannot be retried blindly, so only loads are re-driven.
                  retryCnt <= retryCnt + RW'(1);
                  state    <= DRIVE;
                  J        <= loadJ(dataReg, Q_FB);
                  K        <= loadK(dataReg, Q_FB);
               end else begin
                  state <= IDLE;
                  ERR   <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign IN_READY = (state == IDLE);
   assign BUSY     = (state != IDLE);

endmodule

// File: tb/tb_jk_excite_seq.sv
// Bench for jk_excite_seq: a behavioural JK bank closes the Q_FB loop, directed
// vectors cover load/toggle, then hand-written retry, failure, reset and busy cases.
`timescale 1ns/1ps

module tb_jk_excite_seq;

   localparam int W = 4;

   logic         CLK = 1'b0;
   logic         RST_N;
   logic         IN_VALID;
   logic         IN_READY;
   logic         IN_MODE;
   logic [W-1:0] IN_DATA;
   logic [W-1:0] Q_FB;
   logic [W-1:0] J;
   logic [W-1:0] K;
   logic         BUSY;
   logic         DONE;
   logic         ERR;

   int checks = 0;
   int fails  = 0;

   logic         loadReq;
   logic [W-1:0] loadVal;
   logic         freeze;
   int           dropLimit;
   int           drivesSeen;

   typedef struct {
      logic [W-1:0] qInit;
      logic         mode;
      logic [W-1:0] data;
      logic [W-1:0] expJ;
      logic [W-1:0] expK;
      logic [W-1:0] expQ;
   } vec_t;

   vec_t vecs [7];

   jk_excite_seq #(.WIDTH(W), .MAX_RETRY(2)) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .IN_VALID (IN_VALID),
      .IN_READY (IN_READY),
      .IN_MODE  (IN_MODE),
      .IN_DATA  (IN_DATA),
      .Q_FB     (Q_FB),
      .J        (J),
      .K        (K),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .ERR      (ERR)
   );

   always #5 CLK = ~CLK;

   // Downstream JK bank; can be preloaded, frozen, or told to drop the first drives.
   always @(posedge CLK) begin
      if (loadReq) begin
         Q_FB       <= loadVal;
         drivesSeen <= 0;
      end else if ((J | K) != '0) begin
         if (freeze || drivesSeen < dropLimit)
            drivesSeen <= drivesSeen + 1;
         else
            Q_FB <= (J & ~Q_FB) | (~K & Q_FB);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic stepCycle();
      @(posedge CLK);
      #1;
      checkOutput("doneErrExclusive", 32'(DONE && ERR), 32'd0);
   endtask

   task automatic loadQ(input logic [W-1:0] v);
      loadReq = 1'b1;
      loadVal = v;
      stepCycle();
      loadReq = 1'b0;
   endtask

   // Presents one command for a single edge; returns in the DRIVE cycle.
   task automatic applyStimulus(input logic mode, input logic [W-1:0] data);
      IN_VALID = 1'b1;
      IN_MODE  = mode;
      IN_DATA  = data;
      stepCycle();
      IN_VALID = 1'b0;
   endtask

   initial begin
      int cnt;
      int drives;
      logic sawDone;

      vecs[0] = '{4'b0000, 1'b0, 4'b1010, 4'b1010, 4'b0000, 4'b1010};
      vecs[1] = '{4'b0110, 1'b1, 4'b0011, 4'b0011, 4'b0011, 4'b0101};
      vecs[2] = '{4'b1100, 1'b0, 4'b1100, 4'b0000, 4'b0000, 4'b1100};
      vecs[3] = '{4'b1010, 1'b0, 4'b0101, 4'b0101, 4'b1010, 4'b0101};
      vecs[4] = '{4'b1111, 1'b1, 4'b1111, 4'b1111, 4'b1111, 4'b0000};
      vecs[5] = '{4'b0011, 1'b0, 4'b0110, 4'b0100, 4'b0001, 4'b0110};
      vecs[6] = '{4'b0101, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0101};

      RST_N     = 1'b0;
      IN_VALID  = 1'b1;
      IN_MODE   = 1'b0;
      IN_DATA   = 4'b1111;
      loadReq   = 1'b1;
      loadVal   = '0;
      freeze    = 1'b0;
      dropLimit = 0;

      stepCycle();
      stepCycle();
      checkOutput("rstBusy",  32'(BUSY),     32'd0);
      checkOutput("rstReady", 32'(IN_READY), 32'd1);
      checkOutput("rstJ",     32'(J),        32'd0);
      checkOutput("rstK",     32'(K),        32'd0);
      checkOutput("rstDone",  32'(DONE),     32'd0);
      checkOutput("rstErr",   32'(ERR),      32'd0);
      RST_N    = 1'b1;
      IN_VALID = 1'b0;
      loadReq  = 1'b0;
      stepCycle();

      for (int i = 0; i < 7; i++) begin
         loadQ(vecs[i].qInit);
         applyStimulus(vecs[i].mode, vecs[i].data);
         checkOutput($sformatf("vec%0d_driveJ", i), 32'(J), 32'(vecs[i].expJ));
         checkOutput($sformatf("vec%0d_driveK", i), 32'(K), 32'(vecs[i].expK));
         checkOutput($sformatf("vec%0d_driveBusy", i), 32'(BUSY), 32'd1);
         checkOutput($sformatf("vec%0d_driveReady", i), 32'(IN_READY), 32'd0);
         stepCycle();
         checkOutput($sformatf("vec%0d_checkJK", i), 32'({J, K}), 32'd0);
         checkOutput($sformatf("vec%0d_checkQ", i), 32'(Q_FB), 32'(vecs[i].expQ));
         checkOutput($sformatf("vec%0d_checkDone", i), 32'(DONE), 32'd0);
         stepCycle();
         checkOutput($sformatf("vec%0d_done", i), 32'(DONE), 32'd1);
         checkOutput($sformatf("vec%0d_err", i), 32'(ERR), 32'd0);
         checkOutput($sformatf("vec%0d_readyAtDone", i), 32'(IN_READY), 32'd1);
         stepCycle();
         checkOutput($sformatf("vec%0d_donePulse", i), 32'(DONE), 32'd0);
      end

      // Retry: the bank ignores the first drive, the second one lands.
      dropLimit = 1;
      loadQ(4'b1111);
      applyStimulus(1'b0, 4'b0000);
      checkOutput("retryDrive1J", 32'(J), 32'd0);
      checkOutput("retryDrive1K", 32'(K), 32'hF);
      cnt = 1;
      while (!DONE && !ERR && cnt < 20) begin
         stepCycle();
         cnt++;
         if (cnt == 3) begin
            checkOutput("retryDrive2J", 32'(J), 32'd0);
            checkOutput("retryDrive2K", 32'(K), 32'hF);
         end
      end
      checkOutput("retryLatency", 32'(cnt), 32'd5);
      checkOutput("retryDone", 32'(DONE), 32'd1);
      checkOutput("retryQ", 32'(Q_FB), 32'd0);
      dropLimit = 0;
      stepCycle();

      // Failure: the bank never moves, so all retries run out.
      freeze = 1'b1;
      loadQ(4'b0000);
      applyStimulus(1'b0, 4'b1111);
      drives  = 0;
      sawDone = 1'b0;
      cnt     = 1;
      while (BUSY && cnt < 30) begin
         if (J != '0) drives++;
         stepCycle();
         cnt++;
         if (DONE) sawDone = 1'b1;
      end
      checkOutput("failDrives", 32'(drives), 32'd3);
      checkOutput("failLatency", 32'(cnt), 32'd7);
      checkOutput("failErr", 32'(ERR), 32'd1);
      checkOutput("failNoDone", 32'(sawDone), 32'd0);
      stepCycle();
      stepCycle();
      checkOutput("errSticky", 32'(ERR), 32'd1);

      // A toggle that misses is not retried; the new accept clears the old ERR.
      applyStimulus(1'b1, 4'b0011);
      checkOutput("toggleFailErrCleared", 32'(ERR), 32'd0);
      stepCycle();
      stepCycle();
      checkOutput("toggleFailErr", 32'(ERR), 32'd1);
      checkOutput("toggleFailDone", 32'(DONE), 32'd0);
      checkOutput("toggleFailReady", 32'(IN_READY), 32'd1);
      RST_N = 1'b0;
      stepCycle();
      checkOutput("resetClearsErr", 32'(ERR), 32'd0);
      RST_N  = 1'b1;
      freeze = 1'b0;
      stepCycle();

      // Reset during CHECK aborts silently, and IN_VALID is ignored while in reset.
      loadQ(4'b0000);
      applyStimulus(1'b0, 4'b1010);
      stepCycle();
      checkOutput("midRstInCheck", 32'(BUSY), 32'd1);
      RST_N    = 1'b0;
      IN_VALID = 1'b1;
      IN_DATA  = 4'b0101;
      stepCycle();
      checkOutput("midRstJK", 32'({J, K}), 32'd0);
      checkOutput("midRstBusy", 32'(BUSY), 32'd0);
      checkOutput("midRstDone", 32'(DONE), 32'd0);
      checkOutput("midRstErr", 32'(ERR), 32'd0);
      checkOutput("midRstReady", 32'(IN_READY), 32'd1);
      stepCycle();
      checkOutput("rstIgnoresValid", 32'(BUSY), 32'd0);
      RST_N    = 1'b1;
      IN_VALID = 1'b0;
      stepCycle();
      checkOutput("postRstIdle", 32'({BUSY, DONE}), 32'd0);

      // A second command during DRIVE must not disturb the one in flight.
      loadQ(4'b0000);
      applyStimulus(1'b0, 4'b0011);
      checkOutput("busyDriveJ", 32'(J), 32'h3);
      IN_VALID = 1'b1;
      IN_MODE  = 1'b1;
      IN_DATA  = 4'b1100;
      stepCycle();
      checkOutput("busyCheckJK", 32'({J, K}), 32'd0);
      checkOutput("busyCheckBusy", 32'(BUSY), 32'd1);
      stepCycle();
      checkOutput("busyDone", 32'(DONE), 32'd1);
      checkOutput("busyQ", 32'(Q_FB), 32'h3);
      checkOutput("busyErr", 32'(ERR), 32'd0);
      IN_VALID = 1'b0;
      stepCycle();
      checkOutput("busyNotQueued", 32'(BUSY), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/jk_excite_seq.md
JK_EXCITE_SEQ -- requirements
Module: jk_excite_seq

Interface
REQ-001 Parameter WIDTH, default 4: number of downstream JK flip-flops driven.
REQ-002 Parameter MAX_RETRY, default 2: re-drive attempts allowed after a failed check.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset, synchronous, active-low.
REQ-005 IN_VALID  input  1  command present.
REQ-006 IN_READY  output  1  block can accept a command.
REQ-007 IN_MODE  input  1  0 = load IN_DATA as target, 1 = toggle bits set in IN_DATA.
REQ-008 IN_DATA  input  WIDTH  target word (mode 0) or toggle mask (mode 1).
REQ-009 Q_FB  input  WIDTH  Q outputs fed back from the downstream JK flip-flop bank.
REQ-010 J  output  WIDTH  J excitation, one bit per flip-flop, registered.
REQ-011 K  output  WIDTH  K excitation, one bit per flip-flop, registered.
REQ-012 BUSY  output  1  high in any state other than IDLE.
REQ-013 DONE  output  1  one-cycle pulse: command completed, Q_FB matched expected.
REQ-014 ERR  output  1  last command failed after all retries.

Function
REQ-015 FSM states SHALL be IDLE, DRIVE and CHECK; IN_READY = (state == IDLE).
REQ-016 Accept SHALL occur on a rising edge with IN_VALID && IN_READY; capture mode, IN_DATA and expected word; go to DRIVE; clear ERR; clear retry count.
REQ-017 Expected word: mode 0 SHALL use IN_DATA; mode 1 SHALL use Q_FB ^ IN_DATA, sampled at the accept edge.
REQ-018 Mode 0 excitation, per bit: target 1 and Q_FB 0 -> J=1,K=0; target 0 and Q_FB 1 -> J=0,K=1; equal -> J=0,K=0.
REQ-019 Mode 1 excitation SHALL be J = K = mask.
REQ-020 J/K SHALL be loaded on the edge entering DRIVE, from Q_FB at that edge, and held for exactly the DRIVE cycle; J = K = 0 in every other cycle (downstream holds).
REQ-021 DRIVE SHALL last one cycle, then CHECK.
REQ-022 In CHECK, if Q_FB == expected: go to IDLE and assert DONE for the next cycle only.
REQ-023 In CHECK on mismatch, mode 0 with retry count < MAX_RETRY: increment count and go to DRIVE, recomputing J/K from the current Q_FB.
REQ-024 In CHECK on mismatch, mode 1 or retry count == MAX_RETRY: go to IDLE, set ERR, no DONE.
REQ-025 ERR SHALL stay high until the next accepted command or reset.
REQ-026 Latency, first-pass success: accept edge n; DRIVE in cycle n+1; CHECK n+2; DONE high in cycle n+3, with IN_READY high in that same cycle.
REQ-027 Commands presented while BUSY SHALL be ignored, not queued; IN_VALID may stay high until IN_READY.
REQ-028 DONE and ERR SHALL never be high in the same cycle.
REQ-029 Mode 0 with target already equal to Q_FB SHALL still pass through DRIVE (J=K=0) and CHECK, then pulse DONE.

Reset
REQ-030 RST_N low at a rising edge SHALL force IDLE, J=0, K=0, DONE=0, ERR=0, BUSY=0, retry count 0, captured registers 0, regardless of state.
REQ-031 Reset in DRIVE or CHECK SHALL abort the command with no DONE or ERR; IN_READY goes high in the first cycle after release.
REQ-032 IN_VALID SHALL be ignored in any cycle where RST_N is low.

Verification
REQ-033 Load success: Q_FB=0000, mode 0, IN_DATA=1010 -> DRIVE J=1010, K=0000; model updates Q_FB to 1010; DONE high 3 cycles after accept; ERR=0.
REQ-034 Toggle success: Q_FB=0110, mode 1, IN_DATA=0011 -> J=K=0011; Q_FB becomes 0101; DONE pulses.
REQ-035 Retry: Q_FB=1111, mode 0, IN_DATA=0000; model ignores the first drive -> CHECK fails, second DRIVE J=0000, K=1111 -> DONE; total 5 cycles accept-to-DONE.
REQ-036 Failure: model never updates, mode 0, MAX_RETRY=2 -> 3 DRIVE cycles, then ERR=1 and no DONE; next accept clears ERR.
REQ-037 Reset mid-operation: RST_N low during CHECK -> next cycle J=K=0, BUSY=0, DONE=0, ERR=0, IN_READY=1.
REQ-038 Busy ignore: second IN_VALID pulse during DRIVE with other data -> not captured; J/K and expected word unchanged.
